wb_write_arbiter: RTL

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins. Long-latency results wait
// in a 2-entry in-order buffer and drain on idle cycles. Stale buffered writes are killed.
module wb_write_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd,
   output logic        stall_req,
   output logic [1:0]  pend_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [4:0]  rd_q   [2];
   logic [4:0]  rd_d   [2];
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic [1:0]  live_q, live_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        stall_q, stall_d;

   logic        pipe_wr;
   logic        push;
   logic        pop;
   logic [1:0]  wr_idx;
   logic [1:0]  kill;

   assign pipe_wr   = pipe_we && (pipe_rd != 5'd0);
   assign lu_ready  = (cnt_q < 2'd2);
   assign push      = lu_valid && lu_ready;
   assign pop       = !pipe_wr && (cnt_q != 2'd0);
   assign pend_cnt  = cnt_q;
   assign stall_req = stall_q;

   // Only entries present at cycle start can be killed; a same-cycle push lands after this mask.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_kill
         assign kill[gi] = pipe_wr && (rd_q[gi] == pipe_rd);
      end
   endgenerate

   always_comb begin
      rf_we = 1'b0;
      rf_rd = 5'd0;
      rf_wd = 32'd0;
      if (pipe_wr) begin
         rf_we = 1'b1;
         rf_rd = pipe_rd;
         rf_wd = pipe_data;
      end else if (pop) begin
         rf_we = live_q[0] && (rd_q[0] != 5'd0);
         rf_rd = rd_q[0];
         rf_wd = data_q[0];
      end
   end

   always_comb begin
      rd_d   = rd_q;
      data_d = data_q;
      live_d = live_q & ~kill;
      wr_idx = cnt_q - {1'b0, pop};
      cnt_d  = cnt_q - {1'b0, pop} + {1'b0, push};

      if (pop) begin
         rd_d[0]   = rd_q[1];
         data_d[0] = data_q[1];
         live_d[0] = live_q[1];
         live_d[1] = 1'b0;
      end

      if (push) begin
         rd_d[wr_idx[0]]   = lu_rd;
         data_d[wr_idx[0]] = lu_data;
         live_d[wr_idx[0]] = (lu_rd != 5'd0);
      end

      wcnt_d = wcnt_q;
      if (pop || (cnt_q == 2'd0)) begin
         wcnt_d = 4'd0;
      end else if (wcnt_q < LIMIT) begin
         wcnt_d = wcnt_q + 4'd1;
      end

      // Stall stays up through the pop cycle and drops on the edge that completes the pop.
      stall_d = pop ? 1'b0 : (stall_q || (wcnt_d == LIMIT));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            rd_q[i]   <= 5'd0;
            data_q[i] <= 32'd0;
         end
         live_q  <= 2'b00;
         cnt_q   <= 2'd0;
         wcnt_q  <= 4'd0;
         stall_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         data_q  <= data_d;
         live_q  <= live_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         stall_q <= stall_d;
      end
   end

endmodule
